// File: rtl/scan_led_hex_disp_n.sv
`default_nettype none
// ============================================================================
// Module   : scan_led_hex_disp_n
// Purpose  : Time-multiplexed hex 7-segment scanner, one digit lit at a time.
//            Per-digit decimal point and blank masks, an anti-ghosting blank
//            interval at the start of every digit period, and frame latching
//            of all display inputs so a frame never mixes old and new data.
// Options  : BRIGHTNESS_PWM_EN - adds brightness[3:0] duty-cycle gating.
// Revision : 1.0 - initial release
// ============================================================================
module scan_led_hex_disp_n #(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_W          = 16,
  parameter int BLANK_CYCLES   = 64,
  parameter int AN_ACTIVE_LOW  = 0,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [4*NUM_DIGITS-1:0]       hex_bus,
  input  logic [NUM_DIGITS-1:0]         dp_in,
  input  logic [NUM_DIGITS-1:0]         blank_in,
`ifdef BRIGHTNESS_PWM_EN
  input  logic [3:0]                    brightness,
`endif
  output logic [NUM_DIGITS-1:0]         an,
  output logic [6:0]                    sseg,
  output logic                          dp,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_start
);

  localparam int                    IDX_W       = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0]      C_BLANK_END = DIV_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0]      C_LAST_IDX  = IDX_W'(NUM_DIGITS - 1);
  // "Off" levels; XOR with these converts an active-high value to pin polarity
  localparam logic [NUM_DIGITS-1:0] C_AN_OFF    = (AN_ACTIVE_LOW  != 0) ? '1 : '0;
  localparam logic [6:0]            C_SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                  C_DP_OFF    = (SEG_ACTIVE_LOW != 0);

  // Phase encoding
  localparam logic [0:0] PH_BLANK = 1'b0;
  localparam logic [0:0] PH_SHOW  = 1'b1;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble
  function automatic logic [6:0] f_decode_al(input logic [3:0] i_v);
    logic [6:0] w_p;
    case (i_v)
      4'h0: w_p = 7'b1000000;
      4'h1: w_p = 7'b1111001;
      4'h2: w_p = 7'b0100100;
      4'h3: w_p = 7'b0110000;
      4'h4: w_p = 7'b0011001;
      4'h5: w_p = 7'b0010010;
      4'h6: w_p = 7'b0000010;
      4'h7: w_p = 7'b1111000;
      4'h8: w_p = 7'b0000000;
      4'h9: w_p = 7'b0011000;
      4'hA: w_p = 7'b0001000;
      4'hB: w_p = 7'b0000011;
      4'hC: w_p = 7'b1000110;
      4'hD: w_p = 7'b0100001;
      4'hE: w_p = 7'b0000110;
      default: w_p = 7'b0001110;
    endcase
    return w_p;
  endfunction

  logic [DIV_W-1:0]        r_pre;
  logic [DIV_W-1:0]        w_pre_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic [0:0]              w_phase;
  logic                    w_capture;

  logic [4*NUM_DIGITS-1:0] r_sh_hex;
  logic [NUM_DIGITS-1:0]   r_sh_dp;
  logic [NUM_DIGITS-1:0]   r_sh_blank;

  // Shadow values as seen this cycle (fresh inputs on the capture cycle itself)
  logic [4*NUM_DIGITS-1:0] w_hex_cur;
  logic [NUM_DIGITS-1:0]   w_dp_cur;
  logic [NUM_DIGITS-1:0]   w_blank_cur;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic                    w_bri_ok;

  logic [NUM_DIGITS-1:0]   w_an;
  logic [6:0]              w_sseg;
  logic                    w_dp;

  logic [NUM_DIGITS-1:0]   r_an;
  logic [6:0]              r_sseg;
  logic                    r_dp;
  logic [IDX_W-1:0]        r_digit_idx;
  logic                    r_frame_start;

  assign w_capture   = (r_pre == '0) && (r_idx == '0);
  assign w_hex_cur   = w_capture ? hex_bus  : r_sh_hex;
  assign w_dp_cur    = w_capture ? dp_in    : r_sh_dp;
  assign w_blank_cur = w_capture ? blank_in : r_sh_blank;
  assign w_nib       = w_hex_cur[{r_idx, 2'b00} +: 4];
  assign w_onehot    = NUM_DIGITS'(1) << r_idx;

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0] r_sh_bri;
  logic [3:0] w_bri_cur;

  assign w_bri_cur = w_capture ? brightness : r_sh_bri;
  assign w_bri_ok  = (r_pre[DIV_W-1 -: 4] <= w_bri_cur);

  // Brightness is latched with the rest of the frame
  always_ff @(posedge clk) begin
    if (reset)          r_sh_bri <= 4'hF;
    else if (w_capture) r_sh_bri <= brightness;
  end
`else
  assign w_bri_ok = 1'b1;
`endif

  // State register: prescaler and scanned digit index
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= w_pre_nxt;
      r_idx <= w_idx_nxt;
    end
  end

  // Next state: prescaler wraps naturally, digit advances on the wrap
  always_comb begin
    w_pre_nxt = r_pre + 1'b1;
    w_idx_nxt = r_idx;
    if (&r_pre) w_idx_nxt = (r_idx == C_LAST_IDX) ? '0 : r_idx + 1'b1;
    w_phase = (r_pre < C_BLANK_END) ? PH_BLANK : PH_SHOW;
  end

  // Frame capture of all display inputs at the start of digit 0
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_hex   <= '0;
      r_sh_dp    <= '0;
      r_sh_blank <= '1;
    end else if (w_capture) begin
      r_sh_hex   <= hex_bus;
      r_sh_dp    <= dp_in;
      r_sh_blank <= blank_in;
    end
  end

  // Output decode: everything dark in BLANK or outside the brightness window
  always_comb begin
    w_an   = C_AN_OFF;
    w_sseg = C_SEG_OFF;
    w_dp   = C_DP_OFF;
    if ((w_phase == PH_SHOW) && w_bri_ok) begin
      if (!w_blank_cur[r_idx]) w_an = w_onehot ^ C_AN_OFF;
      w_sseg = f_decode_al(w_nib) ^ ~C_SEG_OFF;
      w_dp   = w_dp_cur[r_idx] ^ C_DP_OFF;
    end
  end

  // Output registers: one cycle behind the prescaler/digit state
  always_ff @(posedge clk) begin
    if (reset) begin
      r_an          <= C_AN_OFF;
      r_sseg        <= C_SEG_OFF;
      r_dp          <= C_DP_OFF;
      r_digit_idx   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_an          <= w_an;
      r_sseg        <= w_sseg;
      r_dp          <= w_dp;
      r_digit_idx   <= r_idx;
      r_frame_start <= w_capture;
    end
  end

  assign an          = r_an;
  assign sseg        = r_sseg;
  assign dp          = r_dp;
  assign digit_idx   = r_digit_idx;
  assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_scan_led_hex_disp_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_scan_led_hex_disp_n
// Purpose  : Self-checking bench for scan_led_hex_disp_n (4 digits, DIV_W=6,
//            BLANK_CYCLES=4). Reference model derives the display from the
//            cycle count since reset. Honours BRIGHTNESS_PWM_EN if defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_scan_led_hex_disp_n;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] hex_bus = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  blank_in = 4'h0;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]  brightness = 4'hF;
`endif
  logic [3:0]  an;
  logic [6:0]  sseg;
  logic        dp;
  logic [1:0]  digit_idx;
  logic        frame_start;

  int n_checks = 0;
  int n_errors = 0;

  scan_led_hex_disp_n #(
    .NUM_DIGITS(4), .DIV_W(6), .BLANK_CYCLES(4), .AN_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
  ) dut (
    .clk(clk), .reset(reset), .hex_bus(hex_bus), .dp_in(dp_in), .blank_in(blank_in),
`ifdef BRIGHTNESS_PWM_EN
    .brightness(brightness),
`endif
    .an(an), .sseg(sseg), .dp(dp), .digit_idx(digit_idx), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Active-low segment table straight from the character list
  logic [6:0] seg_tab [0:15] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Reference model: m_n counts cycles since reset; pre = m_n mod 64,
  // digit = (m_n / 64) mod 4. Expected outputs appear after the clock edge.
  int         m_n = 0;
  logic [15:0] m_hex = 16'h0;
  logic [3:0] m_dp = 4'h0, m_blank = 4'hF, m_bri = 4'hF;
  logic [3:0] e_an = 4'h0;
  logic [6:0] e_sseg = 7'h7F;
  logic       e_dp = 1'b1;
  logic [1:0] e_idx = 2'd0;
  logic       e_fs = 1'b0;

  // Advance model by one clock using current inputs, then move to next negedge
  task automatic tick();
    int pre, idx;
    if (reset) begin
      m_n = 0; m_hex = 16'h0; m_dp = 4'h0; m_blank = 4'hF; m_bri = 4'hF;
      e_an = 4'h0; e_sseg = 7'h7F; e_dp = 1'b1; e_idx = 2'd0; e_fs = 1'b0;
    end else begin
      pre = m_n % 64;
      idx = (m_n / 64) % 4;
      e_fs = (pre == 0) && (idx == 0);
      if (e_fs) begin
        m_hex = hex_bus; m_dp = dp_in; m_blank = blank_in;
`ifdef BRIGHTNESS_PWM_EN
        m_bri = brightness;
`endif
      end
      e_idx = 2'(idx);
      e_an = 4'h0; e_sseg = 7'h7F; e_dp = 1'b1;
      if (pre >= 4 && (pre / 4) <= int'(m_bri)) begin
        if (!m_blank[idx]) e_an = 4'(1 << idx);
        e_sseg = seg_tab[m_hex[idx*4 +: 4]];
        e_dp = ~m_dp[idx];
      end
      m_n++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (an !== 4'h0 || sseg !== 7'h7F || dp !== 1'b1 || digit_idx !== 2'd0 || frame_start !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: got an=%b sseg=%b dp=%b idx=%0d fs=%b, want an=0000 sseg=1111111 dp=1 idx=0 fs=0",
               an, sseg, dp, digit_idx, frame_start);
    end
  endtask

  task automatic test_basic_scan();
    int cnt0, cnt1, bad1;
    int idx_seq[$];
    hex_bus = 16'h3210; dp_in = 4'h0; blank_in = 4'h0;
    reset = 1'b0;
    tick();
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_errors++;
      $display("FAIL first_frame_start: got %b want 1", frame_start);
    end
    cnt0 = 0; cnt1 = 0; bad1 = 0;
    idx_seq.push_back(int'(digit_idx));
    for (int i = 1; i < 257; i++) begin
      tick();
      if (i < 4) begin
        n_checks++;
        if (an !== 4'h0) begin
          n_errors++;
          $display("FAIL blank_interval: cycle %0d got an=%b want 0000", i, an);
        end
      end
      if (i < 128) begin
        if (an == 4'b0001 && sseg == 7'b1000000) cnt0++;
        if (an == 4'b0010) begin
          cnt1++;
          if (sseg !== 7'b1111001) bad1++;
        end
      end
      if (int'(digit_idx) != idx_seq[$]) idx_seq.push_back(int'(digit_idx));
      n_checks++;
      if (an !== e_an || sseg !== e_sseg || dp !== e_dp || digit_idx !== e_idx || frame_start !== e_fs) begin
        n_errors++;
        $display("FAIL basic_model: cyc %0d got an=%b sseg=%b dp=%b idx=%0d fs=%b want an=%b sseg=%b dp=%b idx=%0d fs=%b",
                 i, an, sseg, dp, digit_idx, frame_start, e_an, e_sseg, e_dp, e_idx, e_fs);
      end
    end
    n_checks++;
    if (cnt0 != 60 || cnt1 != 60 || bad1 != 0) begin
      n_errors++;
      $display("FAIL digit_dwell: got d0=%0d d1=%0d bad_d1_seg=%0d want 60 60 0", cnt0, cnt1, bad1);
    end
    n_checks++;
    if (idx_seq.size() != 5 || idx_seq[0] != 0 || idx_seq[1] != 1 || idx_seq[2] != 2 ||
        idx_seq[3] != 3 || idx_seq[4] != 0) begin
      n_errors++;
      $display("FAIL idx_sequence: got %p want '{0,1,2,3,0}", idx_seq);
    end
  endtask

  task automatic test_no_tear();
    int guard;
    int seen_c;
    guard = 0;
    while (!(((m_n / 64) % 4) == 1 && (m_n % 64) >= 8) && guard < 600) begin tick(); guard++; end
    hex_bus = 16'hFEDC;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 400) begin
      tick(); guard++;
      n_checks++;
      if (an !== e_an || sseg !== e_sseg || dp !== e_dp || digit_idx !== e_idx || frame_start !== e_fs) begin
        n_errors++;
        $display("FAIL no_tear_model: got an=%b sseg=%b fs=%b want an=%b sseg=%b fs=%b",
                 an, sseg, frame_start, e_an, e_sseg, e_fs);
      end
    end
    n_checks++;
    if (guard >= 400) begin
      n_errors++;
      $display("FAIL no_tear_timeout: frame_start got 0 want 1");
    end
    seen_c = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (an == 4'b0001 && sseg == 7'b1000110) seen_c++;
    end
    n_checks++;
    if (seen_c != 60) begin
      n_errors++;
      $display("FAIL new_frame_digit0: got %0d cycles of C want 60", seen_c);
    end
  endtask

  task automatic test_blank_dp();
    int guard;
    int bad_an, bad_dp, dp_lit;
    blank_in = 4'b0100; dp_in = 4'b0001;
    guard = 0;
    while (frame_start !== 1'b1 && guard < 400) begin tick(); guard++; end
    bad_an = 0; bad_dp = 0; dp_lit = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (an == 4'b0100) bad_an++;
      if (dp == 1'b0) begin
        dp_lit++;
        if (an != 4'b0001) bad_dp++;
      end
    end
    n_checks++;
    if (bad_an != 0 || guard >= 400) begin
      n_errors++;
      $display("FAIL blank_mask: got %0d cycles an=0100 (guard %0d) want 0", bad_an, guard);
    end
    n_checks++;
    if (bad_dp != 0 || dp_lit != 60) begin
      n_errors++;
      $display("FAIL dp_mask: got stray=%0d lit=%0d want stray=0 lit=60", bad_dp, dp_lit);
    end
    blank_in = 4'h0; dp_in = 4'h0;
  endtask

  task automatic test_midframe_reset();
    int guard;
    guard = 0;
    while (!(((m_n / 64) % 4) == 2 && (m_n % 64) >= 10) && guard < 600) begin tick(); guard++; end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_checks++;
    if (an !== 4'h0 || sseg !== 7'h7F || dp !== 1'b1 || digit_idx !== 2'd0 || frame_start !== 1'b0 || guard >= 600) begin
      n_errors++;
      $display("FAIL midframe_reset: got an=%b sseg=%b dp=%b idx=%0d fs=%b want 0000 1111111 1 0 0",
               an, sseg, dp, digit_idx, frame_start);
    end
    tick();
    n_checks++;
    if (frame_start !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_capture: frame_start got %b want 1", frame_start);
    end
  endtask

  task automatic test_random_onehot();
    for (int i = 0; i < 1024; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        hex_bus = 16'($urandom); dp_in = 4'($urandom); blank_in = 4'($urandom);
      end
      reset = ($urandom_range(0, 299) == 0);
      tick();
      n_checks++;
      if ($countones(an) > 1) begin
        n_errors++;
        $display("FAIL onehot: got an=%b want at most one bit", an);
      end
      n_checks++;
      if (an !== e_an || sseg !== e_sseg || dp !== e_dp || digit_idx !== e_idx || frame_start !== e_fs) begin
        n_errors++;
        $display("FAIL random_model: cyc %0d got an=%b sseg=%b dp=%b idx=%0d fs=%b want an=%b sseg=%b dp=%b idx=%0d fs=%b",
                 i, an, sseg, dp, digit_idx, frame_start, e_an, e_sseg, e_dp, e_idx, e_fs);
      end
    end
    reset = 1'b0;
  endtask

`ifdef BRIGHTNESS_PWM_EN
  task automatic test_brightness();
    int guard, lit;
    int want[2] = '{28, 60};
    logic [3:0] lvl[2] = '{4'd7, 4'd15};
    blank_in = 4'h0;
    for (int k = 0; k < 2; k++) begin
      brightness = lvl[k];
      guard = 0;
      while (frame_start !== 1'b1 && guard < 400) begin tick(); guard++; end
      lit = 0;
      for (int i = 0; i < 63; i++) begin
        tick();
        if (an == 4'b0001) lit++;
      end
      n_checks++;
      if (lit != want[k]) begin
        n_errors++;
        $display("FAIL brightness_%0d: got %0d lit cycles want %0d", lvl[k], lit, want[k]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic_scan();
    test_no_tear();
    test_blank_dp();
    test_midframe_reset();
    test_random_onehot();
`ifdef BRIGHTNESS_PWM_EN
    test_brightness();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
